// File: rtl/mp_regfile_gen2.sv
// Multi-ported register file: combinational reads, highest-port-wins writes, zero register,
// and a self-timed clear sequence. Define MPRF_BYPASS_EN to forward same-cycle writes to reads.
module mp_regfile_gen2 #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RP     = 5,
    parameter int NUM_WP     = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear_i,
    output logic                         busy_o,
    input  logic [NUM_RP*ADDR_WIDTH-1:0] raddr_i,
    output logic [NUM_RP*DATA_WIDTH-1:0] rdata_o,
    input  logic [NUM_WP*ADDR_WIDTH-1:0] waddr_i,
    input  logic [NUM_WP*DATA_WIDTH-1:0] wdata_i,
    input  logic [NUM_WP-1:0]            we_i,
    output logic                         wconflict_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  wconflict_q, wconflict_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    logic [ADDR_WIDTH-1:0] raddr [NUM_RP];
    logic [ADDR_WIDTH-1:0] waddr [NUM_WP];
    logic [DATA_WIDTH-1:0] wdata [NUM_WP];
    logic                  busy;

    assign busy        = (state_q == CLEAR);
    assign busy_o      = busy;
    assign wconflict_o = wconflict_q;

    always_comb begin
        for (int p = 0; p < NUM_RP; p++) begin
            raddr[p] = raddr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
        end
        for (int w = 0; w < NUM_WP; w++) begin
            waddr[w] = waddr_i[w*ADDR_WIDTH +: ADDR_WIDTH];
            wdata[w] = wdata_i[w*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Clear sequencer: pointer walks 1..DEPTH-1 and wraps back to 0 on the last step.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (clear_i) begin
                    state_d = CLEAR;
                    ptr_d   = ADDR_WIDTH'(1);
                end
            end
            CLEAR: begin
                ptr_d = ptr_q + ADDR_WIDTH'(1);
                if (ptr_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = CLEAR;
                ptr_d   = ADDR_WIDTH'(1);
            end
        endcase
    end

    // Ascending port order makes the highest-index enabled port the last assignment, so it wins.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (busy) begin
            mem_d[ptr_q] = '0;
        end else begin
            for (int w = 0; w < NUM_WP; w++) begin
                if (we_i[w] && (waddr[w] != '0)) begin
                    mem_d[waddr[w]] = wdata[w];
                end
            end
        end
        mem_d[0] = '0;
    end

    always_comb begin
        wconflict_d = 1'b0;
        if (!busy) begin
            for (int i = 0; i < NUM_WP; i++) begin
                for (int j = i + 1; j < NUM_WP; j++) begin
                    if (we_i[i] && we_i[j] && (waddr[i] == waddr[j]) && (waddr[i] != '0)) begin
                        wconflict_d = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int p = 0; p < NUM_RP; p++) begin
            if (!busy && (raddr[p] != '0)) begin
                rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = mem_q[raddr[p]];
`ifdef MPRF_BYPASS_EN
                for (int w = 0; w < NUM_WP; w++) begin
                    if (we_i[w] && (waddr[w] == raddr[p])) begin
                        rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = wdata[w];
                    end
                end
`else
                rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = mem_q[raddr[p]];
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= CLEAR;
            ptr_q       <= ADDR_WIDTH'(1);
            wconflict_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            wconflict_q <= wconflict_d;
        end
    end

    // Storage carries no reset; the clear sequence initialises it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

endmodule

// File: tb/tb_mp_regfile_gen2.sv
// Scoreboard bench for mp_regfile_gen2: stimulus queues expectations tagged by cycle,
// a negedge monitor pops and compares them.
module tb_mp_regfile_gen2;
    localparam int AW  = 5;
    localparam int DW  = 32;
    localparam int NRP = 5;
    localparam int NWP = 3;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               clear_i = 1'b0;
    logic               busy_o;
    logic [NRP*AW-1:0]  raddr_i = '0;
    logic [NRP*DW-1:0]  rdata_o;
    logic [NWP*AW-1:0]  waddr_i = '0;
    logic [NWP*DW-1:0]  wdata_i = '0;
    logic [NWP-1:0]     we_i = '0;
    logic               wconflict_o;

    mp_regfile_gen2 #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RP(NRP), .NUM_WP(NWP)
    ) dut (
        .clk(clk), .rst(rst), .clear_i(clear_i), .busy_o(busy_o),
        .raddr_i(raddr_i), .rdata_o(rdata_o),
        .waddr_i(waddr_i), .wdata_i(wdata_i), .we_i(we_i),
        .wconflict_o(wconflict_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          kind;   // 0 rdata, 1 busy, 2 wconflict
        int          port;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t        q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] mon_act;

    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cyc) begin
                case (q[i].kind)
                    0:       mon_act = rdata_o[q[i].port*DW +: DW];
                    1:       mon_act = {31'b0, busy_o};
                    default: mon_act = {31'b0, wconflict_o};
                endcase
                n_vec++;
                if (mon_act !== q[i].val) begin
                    n_bad++;
                    $display("FAIL %s cyc=%0d port=%0d got=%h want=%h",
                             q[i].name, cyc, q[i].port, mon_act, q[i].val);
                end
                q.delete(i);
            end
        end
    end

    task automatic push(int c, int kind, int port, logic [31:0] v, string nm);
        exp_t e;
        e.cyc = c; e.kind = kind; e.port = port; e.val = v; e.name = nm;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_w(int p, int a, logic [31:0] d);
        waddr_i[p*AW +: AW] = AW'(a);
        wdata_i[p*DW +: DW] = d;
        we_i[p] = 1'b1;
    endtask

    task automatic set_r(int p, int a);
        raddr_i[p*AW +: AW] = AW'(a);
    endtask

    task automatic chk_r(int p, logic [31:0] v, string nm);
        push(cyc, 0, p, v, nm);
    endtask

    task automatic chk_busy(logic v, string nm);
        push(cyc, 1, 0, {31'b0, v}, nm);
    endtask

    task automatic chk_wc(logic v, string nm);
        push(cyc, 2, 0, {31'b0, v}, nm);
    endtask

    task automatic busy_window(string nm);
        for (int i = 0; i < 31; i++) begin
            chk_busy(1'b1, nm);
            step();
        end
        chk_busy(1'b0, {nm, "_end"});
    endtask

    task automatic read_all_zero(string nm);
        for (int a = 1; a < 32; a += 5) begin
            for (int p = 0; p < NRP; p++) begin
                set_r(p, ((a + p - 1) % 31) + 1);
                chk_r(p, 32'h0, nm);
            end
            step();
        end
    endtask

    initial begin
        // Reset and post-reset clear
        rst = 1'b1;
        step();
        chk_busy(1'b1, "busy_in_rst");
        chk_wc(1'b0, "wc_in_rst");
        step();
        rst = 1'b0;
        for (int i = 0; i < 31; i++) begin
            chk_busy(1'b1, "busy_post_rst");
            set_r(0, i + 1);
            chk_r(0, 32'h0, "rd_busy_rst");
            step();
        end
        chk_busy(1'b0, "busy_post_rst_end");
        read_all_zero("rd_after_rst");

        // Write then read, and the zero register
        set_w(0, 7, 32'hDEADBEEF);
        step();
        we_i = '0;
        set_r(4, 7);
        chk_r(4, 32'hDEADBEEF, "wr_rd_a7");
        set_w(0, 0, 32'h12345678);
        step();
        we_i = '0;
        set_r(0, 0);
        chk_r(0, 32'h0, "rd_a0");
        chk_wc(1'b0, "wc_single_a0");

        // Collisions
        set_w(0, 9, 32'h1); set_w(1, 9, 32'h2); set_w(2, 9, 32'h3);
        chk_wc(1'b0, "wc_before_coll");
        step();
        we_i = '0;
        set_r(0, 9);
        chk_r(0, 32'h3, "coll_win_a9");
        chk_wc(1'b1, "wc_coll_a9");
        step();
        chk_wc(1'b0, "wc_one_cycle");
        set_w(0, 12, 32'hAA); set_w(2, 12, 32'hBB);
        step();
        we_i = '0;
        set_r(1, 12);
        chk_r(1, 32'hBB, "coll_win_a12");
        chk_wc(1'b1, "wc_coll_a12");
        set_w(0, 0, 32'h11); set_w(1, 0, 32'h22);
        step();
        we_i = '0;
        chk_wc(1'b0, "wc_addr0_pair");
        set_r(0, 0);
        chk_r(0, 32'h0, "rd_a0_after_pair");
        set_w(0, 14, 32'h5);
        waddr_i[1*AW +: AW] = AW'(14);
        step();
        we_i = '0;
        chk_wc(1'b0, "wc_disabled_port");
        set_r(2, 14);
        chk_r(2, 32'h5, "rd_a14");

        // Same-cycle read of a written address
        set_r(0, 3);
        set_w(1, 3, 32'hA5A5A5A5);
`ifdef MPRF_BYPASS_EN
        chk_r(0, 32'hA5A5A5A5, "byp_same_cycle");
`else
        chk_r(0, 32'h0, "byp_same_cycle");
`endif
        step();
        we_i = '0;
        chk_r(0, 32'hA5A5A5A5, "byp_next_cycle");
        step();

        // Fill 1..31 with nonzero data
        for (int a = 1; a < 32; a += 3) begin
            we_i = '0;
            for (int p = 0; p < NWP; p++) begin
                if (a + p <= 31) set_w(p, a + p, 32'h1000_0000 | (a + p));
            end
            step();
        end
        we_i = '0;
        for (int p = 0; p < 4; p++) begin
            set_r(p, p + 1);
            chk_r(p, 32'h1000_0000 | (p + 1), "fill_rd");
        end
        set_r(4, 31);
        chk_r(4, 32'h1000_001F, "fill_rd_a31");
        step();

        // Clear with a same-cycle write, then ignored writes and a second clear pulse
        clear_i = 1'b1;
        set_w(0, 20, 32'hFFFF);
        step();
        for (int i = 0; i < 31; i++) begin
            we_i = '0;
            clear_i = (i == 10);
            chk_busy(1'b1, "busy_clr");
            chk_wc(1'b0, "wc_during_clr");
            set_r(0, i + 1);
            chk_r(0, 32'h0, "rd_during_clr");
            set_w(0, 5, 32'hCAFE0000); set_w(1, 5, 32'hCAFE0001);
            step();
        end
        clear_i = 1'b0;
        we_i = '0;
        chk_busy(1'b0, "busy_clr_end");
        chk_wc(1'b0, "wc_after_clr");
        read_all_zero("rd_after_clr");

        // Reset in the middle of a clear restarts it
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        for (int i = 0; i < 10; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        busy_window("busy_mid_rst");

        set_w(2, 31, 32'h600DF00D);
        step();
        we_i = '0;
        set_r(3, 31);
        chk_r(3, 32'h600DF00D, "wr_rd_a31_final");
        step();
        step();

        n_vec++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain left=%0d want=0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/mp_regfile_gen2.md
MP_REGFILE_GEN2 -- requirements
Module: mp_regfile_gen2

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5: register address width; depth = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: register data width.
REQ-003 SHALL have parameter NUM_RP, default 5, range 1..8: number of read ports.
REQ-004 SHALL have parameter NUM_WP, default 3, range 1..4: number of write ports.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port clear_i, input, 1 bit: request a full-array clear.
REQ-008 SHALL have port busy_o, output, 1 bit: high while the clear sequence runs.
REQ-009 SHALL have port raddr_i, input, NUM_RP*ADDR_WIDTH bits: packed read addresses; port p uses slice p.
REQ-010 SHALL have port rdata_o, output, NUM_RP*DATA_WIDTH bits: packed read data.
REQ-011 SHALL have port waddr_i, input, NUM_WP*ADDR_WIDTH bits: packed write addresses.
REQ-012 SHALL have port wdata_i, input, NUM_WP*DATA_WIDTH bits: packed write data.
REQ-013 SHALL have port we_i, input, NUM_WP bits: per-port write enables.
REQ-014 SHALL have port wconflict_o, output, 1 bit: registered flag, high for one cycle after two or more enabled write ports target the same nonzero address.

Function
REQ-015 Reads SHALL be combinational: rdata_o slice p equals the stored word at raddr_i slice p in the same cycle.
REQ-016 Address 0 SHALL always read as zero; writes to address 0 SHALL be discarded.
REQ-017 An enabled write SHALL update storage on the next rising edge of clk; new data is visible to reads in the cycle after.
REQ-018 When several enabled write ports target the same address, the highest-index port SHALL win.
REQ-019 wconflict_o SHALL be asserted in cycle N+1 exactly when a same-address collision of enabled ports occurs in cycle N, excluding address 0 and excluding cycles with busy_o high.
REQ-020 The FSM SHALL have the states IDLE and CLEAR.
REQ-021 In IDLE with clear_i high, the FSM SHALL enter CLEAR on the next edge with the clear pointer set to 1.
REQ-022 In CLEAR, each cycle SHALL write zero to the pointer address and increment the pointer.
REQ-023 After writing address 2**ADDR_WIDTH-1, the FSM SHALL return to IDLE; the pointer SHALL wrap rather than overflow.
REQ-024 A CLEAR sequence SHALL take exactly 2**ADDR_WIDTH-1 cycles, which is 31 at the default.
REQ-025 busy_o SHALL equal (state==CLEAR).
REQ-026 While busy_o is high, all we_i SHALL be ignored and every rdata_o slice SHALL read zero.
REQ-027 clear_i asserted during CLEAR SHALL be ignored; the sequence neither restarts nor extends.
REQ-028 clear_i asserted in the same cycle as writes in IDLE SHALL still commit those writes; the clear then overwrites them.

Reset
REQ-029 rst high SHALL asynchronously force state=CLEAR, pointer=1, and wconflict_o=0.
REQ-030 busy_o SHALL therefore be 1 during and after reset until the post-reset clear completes.
REQ-031 The storage array SHALL have no reset flops; it is initialised only by the CLEAR sequence.
REQ-032 rst asserted mid-CLEAR SHALL restart the sequence at address 1.

Configuration
REQ-033 Macro MPRF_BYPASS_EN defined: a read whose address matches an enabled write in the same cycle SHALL return that write's wdata, using highest-index-port priority, with address 0 still zero and busy_o still forcing zero.
REQ-034 Macro MPRF_BYPASS_EN undefined: such a read SHALL return the old stored value, and the new value appears in the next cycle.

Verification
REQ-035 Reset scenario: assert rst, then release it; busy_o SHALL be high for exactly 31 cycles, and all 5 read ports SHALL then read 0 from addresses 1..31.
REQ-036 Write/read scenario: write 0xDEADBEEF to address 7 via port 0; the next cycle raddr port 4 = 7 SHALL give 0xDEADBEEF. Writing 0x12345678 to address 0 SHALL leave address 0 reading 0.
REQ-037 Collision scenario: ports 0, 1 and 2 all write address 9 with 0x1, 0x2 and 0x3 in the same cycle; the next cycle SHALL show address 9 = 0x3 and wconflict_o = 1 for exactly one cycle. Ports 0 and 1 both writing address 0 SHALL give wconflict_o = 0.
REQ-038 Bypass scenario: port 1 writes 0xA5A5A5A5 to address 3 while read port 0 reads address 3 in the same cycle. With MPRF_BYPASS_EN, rdata port 0 SHALL be 0xA5A5A5A5 in that cycle. Without it, it SHALL show the old value 0, then 0xA5A5A5A5 the next cycle.
REQ-039 Clear scenario: fill addresses 1..31 with nonzero data, then pulse clear_i. During the clear, writes and a second clear_i pulse SHALL be ignored and reads SHALL return 0. After 31 cycles all addresses SHALL read 0.
REQ-040 Mid-clear reset scenario: pulse rst at cycle 10 of a CLEAR; busy_o SHALL stay high for 31 more cycles after rst is released.
